cpu_timing: RTL and testbench
=============================

# cpu_timing

Timing generator and instruction-register stage that sits directly upstream of the 6502 datapath/decode. It sequences the T-states of each instruction and loads the opcode into IR on the fetch cycle. It arbitrates RESET/NMI/IRQ by forcing a BRK (8'h00) into IR. Its outputs (IR, T-state, SYNC, interrupt source) index the decode logic that drives the datapath control lines (DLDB, PCLADL, SBAC, …).

## Interface
Parameters:
- T_MAX, 7: highest legal T-state; T_MAX→0 is a forced wrap.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_data  in  8  data bus; holds the opcode during the fetch cycle
- i_rdy  in  1  1 = advance; 0 = stall this cycle
- i_t_end  in  1  from decode: current cycle is the last of the instruction
- i_t_skip  in  1  from decode: skip the next T-state (no page cross / branch not taken)
- i_irq_n  in  1  IRQ, active-low, level-sensitive
- i_nmi_n  in  1  NMI, active-low, falling-edge-sensitive
- i_p_i  in  1  P.I (interrupt-disable) flag
- o_ir  out  8  instruction register
- o_t  out  3  current T-state; 0 = opcode fetch
- o_sync  out  1  high while o_t==0
- o_force_brk  out  1  current instruction is a hardware-forced BRK
- o_brk_src  out  2  0 = software BRK/none, 1 = IRQ, 2 = NMI, 3 = RESET
- o_pc_inhibit  out  1  = o_force_brk; decode suppresses PC increment
- o_wr_inhibit  out  1  high when o_force_brk && o_brk_src==3; stack writes become reads

## Operation
- **Reset (async, i_rst=1):**
  - t=0; ir=8'h00
  - rst_pend=1, nmi_pend=0, nmi_prev=1
  - force_brk=0, brk_src=0
  - All outputs follow: o_sync=1, o_wr_inhibit=0.
- **Fetch edge** (t==0 && i_rdy): selects the new instruction by priority. In every case t←1.
  - rst_pend: ir←00, force_brk←1, brk_src←3, rst_pend←0.
  - Else nmi_pend: ir←00, force_brk←1, brk_src←2, nmi_pend←0.
  - Else (!i_irq_n && !i_p_i): ir←00, force_brk←1, brk_src←1.
  - Else: ir←i_data, force_brk←0, brk_src←0.
- **Non-fetch edge with i_rdy:** evaluated in this order.
  - t==T_MAX → t←0.
  - Else i_t_end → t←0.
  - Else i_t_skip → t←min(t+2, T_MAX).
  - Else t←t+1.
  - i_t_end and i_t_skip together: i_t_end wins.
- **Stall (i_rdy=0):** t, ir, force_brk, brk_src and the pend-clears all hold.
- **NMI edge detector:** runs every cycle regardless of i_rdy.
  - nmi_prev←i_nmi_n.
  - nmi_pend←1 when nmi_prev && !i_nmi_n.
  - If a set and a clear land in the same edge, set wins; a new edge is never lost.
  - NMI held low causes exactly one pend.
- **IRQ:** not latched; sampled only at the fetch edge and masked by i_p_i at that edge.
- **Arbitration:** NMI arriving during a forced RESET/IRQ sequence is taken at the next fetch.

## Timing
- o_ir, o_t, o_force_brk and o_brk_src are registered. o_sync, o_pc_inhibit and o_wr_inhibit are combinational from registers only, with no input-to-output paths.
- IR is valid from the first cycle with o_t==1 and holds until the next fetch edge.
- NMI latency: a falling edge sampled at clock edge N sets nmi_pend at N. It is taken at the first fetch edge ≥ N+1.
- Minimum instruction length is 2 cycles (t=0, t=1 with i_t_end).
- Reset deasserted asynchronously: the first fetch edge after release loads the RESET BRK.

## Structure
- Package cpu_pkg holds:
  - brk_src_t enum (NONE, IRQ, NMI, RESET);
  - localparams OP_BRK=8'h00 and T_FETCH=3'd0.
  - The datapath decode shares these.
- One sub-module, nmi_edge_det (i_clk, i_rst, i_nmi_n, i_clr → o_pend), holds nmi_prev/nmi_pend with set-over-clear priority.
- Estimated size is ~150–250 lines of RTL.

## Test plan
- Reset then i_data=8'hA9, i_irq_n=1, i_nmi_n=1: first fetch gives o_ir=00, o_brk_src=3, o_wr_inhibit=1. The next fetch gives o_ir=A9, o_force_brk=0.
- Normal 2-cycle op: fetch with i_data=8'hEA, i_t_end at t=1 → o_t sequence 0,1,0 with o_sync 1,0,1.
- i_nmi_n pulsed low for 1 cycle mid-instruction with i_irq_n=0, i_p_i=0: next fetch gives o_brk_src=2. The fetch after the BRK ends gives o_brk_src=1.
- i_irq_n=0 with i_p_i=1 at fetch, i_data=8'h18: o_ir=18, o_force_brk=0.
- i_rdy=0 for 3 cycles at t=2: o_t stays 2, o_ir unchanged. An NMI falling edge during the stall is still pended.
- i_t_skip at t=2 → o_t=4. With i_t_end never asserted, o_t reaches 7 and then wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the timing generator and the datapath decode:
//   brk_src_t - why the current instruction is a BRK (none/IRQ/NMI/RESET)
//   OP_BRK    - opcode forced into IR for hardware interrupts
//   T_FETCH   - T-state of the opcode fetch cycle
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    BRK_NONE  = 2'd0,
    BRK_IRQ   = 2'd1,
    BRK_NMI   = 2'd2,
    BRK_RESET = 2'd3
  } brk_src_t;

  localparam logic [7:0] OP_BRK  = 8'h00;
  localparam logic [2:0] T_FETCH = 3'd0;

endpackage : cpu_pkg

// File: rtl/nmi_edge_det.sv
// -----------------------------------------------------------------------------
// nmi_edge_det
// Falling-edge detector for the active-low NMI line. Runs every cycle,
// independent of RDY, so an edge seen during a stall is never lost.
// Ports:
//   i_clk   - system clock
//   i_rst   - asynchronous active-high reset
//   i_nmi_n - NMI input, active low
//   i_clr   - the pending NMI is being taken this edge
//   o_pend  - an NMI falling edge is waiting to be serviced
// -----------------------------------------------------------------------------
module nmi_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_nmi_n,
  input  logic i_clr,
  output logic o_pend
);

  logic r_nmi_prev;
  logic r_nmi_pend;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_nmi_prev <= 1'b1;
      r_nmi_pend <= 1'b0;
    end else begin
      r_nmi_prev <= i_nmi_n;
      // A new edge outranks the clear, so an NMI arriving on the very edge
      // that services the previous one stays pending.
      if (r_nmi_prev && !i_nmi_n) begin
        r_nmi_pend <= 1'b1;
      end else if (i_clr) begin
        r_nmi_pend <= 1'b0;
      end
    end
  end

  assign o_pend = r_nmi_pend;

endmodule : nmi_edge_det

// File: rtl/cpu_timing.sv
// -----------------------------------------------------------------------------
// cpu_timing
// T-state sequencer and instruction register for the 6502 core. Loads the
// opcode on the fetch cycle, or forces a BRK for RESET/NMI/IRQ (in that
// priority), and steps the T-state under control of the decode logic.
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_data        - data bus (opcode during fetch)
//   i_rdy         - 1 = advance, 0 = stall
//   i_t_end       - decode: this is the last cycle of the instruction
//   i_t_skip      - decode: skip the next T-state
//   i_irq_n       - IRQ, active low, level sensitive
//   i_nmi_n       - NMI, active low, falling-edge sensitive
//   i_p_i         - interrupt-disable flag
//   o_ir          - instruction register
//   o_t           - current T-state (0 = fetch)
//   o_sync        - high during the fetch cycle
//   o_force_brk   - current instruction is a hardware-forced BRK
//   o_brk_src     - source of the forced BRK (brk_src_t encoding)
//   o_pc_inhibit  - suppress PC increment (forced BRK)
//   o_wr_inhibit  - turn stack writes into reads (RESET sequence)
// -----------------------------------------------------------------------------
module cpu_timing
  import cpu_pkg::*;
#(
  parameter int T_MAX = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_rdy,
  input  logic       i_t_end,
  input  logic       i_t_skip,
  input  logic       i_irq_n,
  input  logic       i_nmi_n,
  input  logic       i_p_i,
  output logic [7:0] o_ir,
  output logic [2:0] o_t,
  output logic       o_sync,
  output logic       o_force_brk,
  output logic [1:0] o_brk_src,
  output logic       o_pc_inhibit,
  output logic       o_wr_inhibit
);

  localparam logic [2:0] T_LAST    = 3'(T_MAX);
  localparam logic [3:0] T_LAST_X4 = 4'(T_MAX);

  logic [2:0] r_t;
  logic [7:0] r_ir;
  logic       r_force_brk;
  brk_src_t   r_brk_src;
  logic       r_rst_pend;

  logic [2:0] w_t_next;
  logic [7:0] w_ir_next;
  logic       w_force_brk_next;
  brk_src_t   w_brk_src_next;
  logic       w_rst_pend_next;
  logic       w_nmi_pend;
  logic       w_nmi_clr;
  logic [3:0] w_t_plus2;

  nmi_edge_det u_nmi_edge_det (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_nmi_n (i_nmi_n),
    .i_clr   (w_nmi_clr),
    .o_pend  (w_nmi_pend)
  );

  // One extra bit so the skip saturation cannot wrap past T_MAX.
  assign w_t_plus2 = {1'b0, r_t} + 4'd2;

  // NOTE: every signal is given its hold value first, so no path through the
  // block leaves one unassigned and no latch is inferred.
  always_comb begin
    w_t_next         = r_t;
    w_ir_next        = r_ir;
    w_force_brk_next = r_force_brk;
    w_brk_src_next   = r_brk_src;
    w_rst_pend_next  = r_rst_pend;
    w_nmi_clr        = 1'b0;

    if (i_rdy) begin
      if (r_t == T_FETCH) begin
        w_t_next = 3'd1;
        if (r_rst_pend) begin
          w_ir_next        = OP_BRK;
          w_force_brk_next = 1'b1;
          w_brk_src_next   = BRK_RESET;
          w_rst_pend_next  = 1'b0;
        end else if (w_nmi_pend) begin
          w_ir_next        = OP_BRK;
          w_force_brk_next = 1'b1;
          w_brk_src_next   = BRK_NMI;
          w_nmi_clr        = 1'b1;
        end else if (!i_irq_n && !i_p_i) begin
          w_ir_next        = OP_BRK;
          w_force_brk_next = 1'b1;
          w_brk_src_next   = BRK_IRQ;
        end else begin
          w_ir_next        = i_data;
          w_force_brk_next = 1'b0;
          w_brk_src_next   = BRK_NONE;
        end
      end else if (r_t == T_LAST) begin
        w_t_next = T_FETCH;
      end else if (i_t_end) begin
        w_t_next = T_FETCH;
      end else if (i_t_skip) begin
        w_t_next = (w_t_plus2 > T_LAST_X4) ? T_LAST : w_t_plus2[2:0];
      end else begin
        w_t_next = r_t + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_t         <= T_FETCH;
      r_ir        <= OP_BRK;
      r_force_brk <= 1'b0;
      r_brk_src   <= BRK_NONE;
      r_rst_pend  <= 1'b1;
    end else begin
      r_t         <= w_t_next;
      r_ir        <= w_ir_next;
      r_force_brk <= w_force_brk_next;
      r_brk_src   <= w_brk_src_next;
      r_rst_pend  <= w_rst_pend_next;
    end
  end

  assign o_ir         = r_ir;
  assign o_t          = r_t;
  assign o_sync       = (r_t == T_FETCH);
  assign o_force_brk  = r_force_brk;
  assign o_brk_src    = r_brk_src;
  assign o_pc_inhibit = r_force_brk;
  assign o_wr_inhibit = r_force_brk && (r_brk_src == BRK_RESET);

endmodule : cpu_timing

// File: tb/tb_cpu_timing.sv
// -----------------------------------------------------------------------------
// tb_cpu_timing
// Drives directed and random cycles into cpu_timing. Each driven cycle runs a
// cycle-level reference model and queues the expected outputs after the next
// rising edge; a monitor samples the DUT just after each rising edge and
// compares against the queue head.
// -----------------------------------------------------------------------------
module tb_cpu_timing;

  typedef struct {
    logic [7:0] ir;
    logic [2:0] t;
    logic       sync;
    logic       force_brk;
    logic [1:0] src;
    logic       pc_inh;
    logic       wr_inh;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rdy = 1'b1;
  logic       t_end = 1'b0;
  logic       t_skip = 1'b0;
  logic       irq_n = 1'b1;
  logic       nmi_n = 1'b1;
  logic       p_i = 1'b0;
  logic [7:0] ir;
  logic [2:0] t;
  logic       sync, force_brk, pc_inh, wr_inh;
  logic [1:0] brk_src;

  int checks = 0;
  int passes = 0;
  exp_t exp_q[$];

  // Reference model state
  int m_t, m_ir, m_src;
  bit m_force, m_rst_pend, m_nmi_pend, m_nmi_prev;

  cpu_timing #(.T_MAX(7)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (data),
    .i_rdy        (rdy),
    .i_t_end      (t_end),
    .i_t_skip     (t_skip),
    .i_irq_n      (irq_n),
    .i_nmi_n      (nmi_n),
    .i_p_i        (p_i),
    .o_ir         (ir),
    .o_t          (t),
    .o_sync       (sync),
    .o_force_brk  (force_brk),
    .o_brk_src    (brk_src),
    .o_pc_inhibit (pc_inh),
    .o_wr_inhibit (wr_inh)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
  endtask

  task automatic model_reset();
    m_t = 0; m_ir = 0; m_src = 0; m_force = 0;
    m_rst_pend = 1; m_nmi_pend = 0; m_nmi_prev = 1;
  endtask

  // Apply the architectural rules for one rising edge with the current inputs.
  task automatic model_step();
    bit nmi_fall, nmi_taken;
    exp_t e;
    nmi_fall  = m_nmi_prev && !nmi_n;
    nmi_taken = 0;
    if (rdy) begin
      if (m_t == 0) begin
        m_t = 1;
        if (m_rst_pend) begin
          m_ir = 0; m_force = 1; m_src = 3; m_rst_pend = 0;
        end else if (m_nmi_pend) begin
          m_ir = 0; m_force = 1; m_src = 2; nmi_taken = 1;
        end else if (!irq_n && !p_i) begin
          m_ir = 0; m_force = 1; m_src = 1;
        end else begin
          m_ir = int'(data); m_force = 0; m_src = 0;
        end
      end else if (m_t == 7 || t_end) begin
        m_t = 0;
      end else if (t_skip) begin
        m_t = (m_t + 2 > 7) ? 7 : m_t + 2;
      end else begin
        m_t = m_t + 1;
      end
    end
    if (nmi_fall) m_nmi_pend = 1;
    else if (nmi_taken) m_nmi_pend = 0;
    m_nmi_prev = nmi_n;

    e.ir        = 8'(m_ir);
    e.t         = 3'(m_t);
    e.sync      = (m_t == 0);
    e.force_brk = m_force;
    e.src       = 2'(m_src);
    e.pc_inh    = m_force;
    e.wr_inh    = m_force && (m_src == 3);
    exp_q.push_back(e);
  endtask

  // Called at a falling edge: set inputs, queue expectation, wait one cycle.
  task automatic drive(input bit r, input bit te, input bit ts, input bit irqn,
                       input bit nmin, input bit pi, input logic [7:0] d);
    rdy = r; t_end = te; t_skip = ts; irq_n = irqn; nmi_n = nmin; p_i = pi; data = d;
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_t",     8'(t), 8'h00);
    check("rst_ir",    ir, 8'h00);
    check("rst_sync",  8'(sync), 8'h01);
    check("rst_force", 8'(force_brk), 8'h00);
    check("rst_src",   8'(brk_src), 8'h00);
    check("rst_wrinh", 8'(wr_inh), 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compare the queue head against the DUT just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ir",      ir, e.ir);
        check("t",       8'(t), 8'(e.t));
        check("sync",    8'(sync), 8'(e.sync));
        check("force",   8'(force_brk), 8'(e.force_brk));
        check("brk_src", 8'(brk_src), 8'(e.src));
        check("pc_inh",  8'(pc_inh), 8'(e.pc_inh));
        check("wr_inh",  8'(wr_inh), 8'(e.wr_inh));
      end
    end
  end

  initial begin
    @(negedge clk);
    apply_reset();

    // RESET BRK first, then the real opcode.
    drive(1, 0, 0, 1, 1, 0, 8'hA9);
    check("dir_rst_ir", ir, 8'h00);
    check("dir_rst_src", 8'(brk_src), 8'h03);
    check("dir_rst_wrinh", 8'(wr_inh), 8'h01);
    drive(1, 1, 0, 1, 1, 0, 8'hA9);
    drive(1, 0, 0, 1, 1, 0, 8'hA9);
    check("dir_a9_ir", ir, 8'hA9);
    check("dir_a9_force", 8'(force_brk), 8'h00);
    drive(1, 1, 0, 1, 1, 0, 8'h00);

    // Two-cycle NOP: t 0,1,0 with sync 1,0,1.
    check("dir_nop_sync0", 8'(sync), 8'h01);
    drive(1, 0, 0, 1, 1, 0, 8'hEA);
    check("dir_nop_t1", 8'(t), 8'h01);
    check("dir_nop_sync1", 8'(sync), 8'h00);
    drive(1, 1, 0, 1, 1, 0, 8'hEA);
    check("dir_nop_t0", 8'(t), 8'h00);
    check("dir_nop_sync2", 8'(sync), 8'h01);

    // NMI pulse mid-instruction with IRQ also asserted: NMI first, then IRQ.
    drive(1, 0, 0, 1, 1, 0, 8'hEA);
    drive(1, 0, 0, 0, 0, 0, 8'hEA);
    drive(1, 1, 0, 0, 1, 0, 8'hEA);
    drive(1, 0, 0, 0, 1, 0, 8'hEA);
    check("dir_nmi_src", 8'(brk_src), 8'h02);
    drive(1, 1, 0, 0, 1, 0, 8'hEA);
    drive(1, 0, 0, 0, 1, 0, 8'hEA);
    check("dir_irq_src", 8'(brk_src), 8'h01);
    drive(1, 1, 0, 0, 1, 0, 8'hEA);

    // Masked IRQ loads the opcode.
    drive(1, 0, 0, 0, 1, 1, 8'h18);
    check("dir_mask_ir", ir, 8'h18);
    check("dir_mask_force", 8'(force_brk), 8'h00);
    drive(1, 0, 0, 1, 1, 1, 8'h00);
    // Stall at t=2 with an NMI edge inside it.
    drive(0, 0, 0, 1, 0, 1, 8'h00);
    drive(0, 0, 0, 1, 1, 1, 8'h00);
    drive(0, 0, 0, 1, 1, 1, 8'h00);
    check("dir_stall_t", 8'(t), 8'h02);
    check("dir_stall_ir", ir, 8'h18);
    // Skip to 4, then run to 7 and wrap.
    drive(1, 0, 1, 1, 1, 1, 8'h00);
    check("dir_skip_t", 8'(t), 8'h04);
    drive(1, 0, 0, 1, 1, 1, 8'h00);
    drive(1, 0, 0, 1, 1, 1, 8'h00);
    drive(1, 0, 0, 1, 1, 1, 8'h00);
    check("dir_tmax_t", 8'(t), 8'h07);
    drive(1, 0, 0, 1, 1, 1, 8'h00);
    check("dir_wrap_t", 8'(t), 8'h00);
    drive(1, 0, 0, 1, 1, 1, 8'h77);
    check("dir_stall_nmi_src", 8'(brk_src), 8'h02);
    drive(1, 1, 0, 1, 1, 1, 8'h00);

    // Random traffic, with one reset in the middle.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 1500; i++) begin
        drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) < 2, $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) != 0, $urandom_range(0, 1) == 1,
              8'($urandom));
      end
      if (pass == 0) apply_reset();
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain", 8'(exp_q.size()), 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_cpu_timing
